alu_operand_fetch: RTL and testbench

- Upstream feeder for the 8-bit ALU in the 6502-style core.
- Takes a decoded addressing mode plus instruction operand bytes and resolves the effective address (EA), issuing the required data-memory reads.
- Presents the A operand and the memory/immediate B operand to the ALU with a one-cycle valid pulse.
- Reads only; write-back is handled by the store path, which uses the exported EA.

---
 rtl/alu_operand_fetch_pkg.sv | 34 +++
 rtl/alu_operand_fetch_ea_calc.sv | 28 ++
 rtl/alu_operand_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_alu_operand_fetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_fetch_pkg.sv
// Shared types for the operand-fetch path feeding the 8-bit ALU:
// addressing-mode codes, fetch FSM states and the zero-page constant.
package alu_operand_fetch_pkg;

  typedef enum logic [3:0] {
    AM_IMM  = 4'h0,
    AM_ZP   = 4'h1,
    AM_ZPX  = 4'h2,
    AM_ZPY  = 4'h3,
    AM_ABS  = 4'h4,
    AM_ABSX = 4'h5,
    AM_ABSY = 4'h6,
    AM_INDX = 4'h7,
    AM_INDY = 4'h8
  } addr_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR_LO,
    ST_PTR_HI,
    ST_EA_FORM,
    ST_FIX,
    ST_RD,
    ST_CAP
  } state_e;

  localparam logic [7:0] ZERO_PAGE = 8'h00;

  // Codes above the last defined mode are reserved and fall back to immediate.
  function automatic logic is_reserved_mode(input logic [3:0] mode);
    return mode > AM_INDY;
  endfunction

endpackage

// File: rtl/alu_operand_fetch_ea_calc.sv
// Combinational effective-address adder: base plus 8-bit index, either as a
// full 16-bit wrap with page-cross detection or confined to the zero page.
module alu_operand_fetch_ea_calc
  import alu_operand_fetch_pkg::*;
(
  input  logic [15:0] base,
  input  logic [7:0]  idx,
  input  logic        zp_wrap,
  output logic [15:0] ea,
  output logic        page_cross
);

  logic [15:0] sum;
  logic [7:0]  zp_lo;

  always_comb begin
    sum   = base + {8'h00, idx};
    zp_lo = base[7:0] + idx;
    if (zp_wrap) begin
      ea         = {ZERO_PAGE, zp_lo};
      page_cross = 1'b0;
    end else begin
      ea         = sum;
      page_cross = (sum[15:8] != base[15:8]);
    end
  end

endmodule

// File: rtl/alu_operand_fetch.sv
// Resolves the effective address for a decoded addressing mode, issues the
// data reads and presents A/B operands to the ALU with a one-cycle valid.
module alu_operand_fetch
  import alu_operand_fetch_pkg::*;
#(
  parameter int unsigned PAGE_PENALTY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  addr_mode,
  input  logic [7:0]  opnd_lo,
  input  logic [7:0]  opnd_hi,
  input  logic [7:0]  reg_a,
  input  logic [7:0]  reg_x,
  input  logic [7:0]  reg_y,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        op_valid,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [15:0] ea,
  output logic        page_cross,
  output logic        mode_err
);

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  ptr_lo_q, ptr_lo_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] ea_work_q, ea_work_d;
  logic        cross_work_q, cross_work_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [15:0] ea_q, ea_d;
  logic        page_cross_q, page_cross_d;
  logic        op_valid_q, op_valid_d;
  logic        mode_err_q, mode_err_d;

  // Mode decode of the live inputs, only meaningful on the accept edge.
  logic        dec_ind, dec_zp_wrap, dec_imm;
  logic [7:0]  dec_dir_idx, dec_ptr, dec_ind_idx;
  logic [15:0] dir_ea, ind_ea;
  logic        dir_cross, ind_cross;
  logic [7:0]  ptr_next;
  logic        penalty_en;

  assign penalty_en = (PAGE_PENALTY != 0);
  assign ptr_next   = ptr_q + 8'd1;

  always_comb begin
    dec_imm     = 1'b0;
    dec_ind     = 1'b0;
    dec_zp_wrap = 1'b0;
    dec_dir_idx = 8'h00;
    dec_ptr     = opnd_lo;
    dec_ind_idx = 8'h00;
    case (addr_mode)
      AM_ZP:   dec_zp_wrap = 1'b1;
      AM_ZPX:  begin dec_zp_wrap = 1'b1; dec_dir_idx = reg_x; end
      AM_ZPY:  begin dec_zp_wrap = 1'b1; dec_dir_idx = reg_y; end
      AM_ABS:  ;
      AM_ABSX: dec_dir_idx = reg_x;
      AM_ABSY: dec_dir_idx = reg_y;
      AM_INDX: begin dec_ind = 1'b1; dec_ptr = opnd_lo + reg_x; end
      AM_INDY: begin dec_ind = 1'b1; dec_ind_idx = reg_y; end
      default: dec_imm = 1'b1;
    endcase
  end

  alu_operand_fetch_ea_calc u_ea_dir (
    .base       ({opnd_hi, opnd_lo}),
    .idx        (dec_dir_idx),
    .zp_wrap    (dec_zp_wrap),
    .ea         (dir_ea),
    .page_cross (dir_cross)
  );

  // Pointer high byte arrives on mem_rdata during EA_FORM; X-indirect uses idx 0.
  alu_operand_fetch_ea_calc u_ea_ind (
    .base       ({mem_rdata, ptr_lo_q}),
    .idx        (idx_q),
    .zp_wrap    (1'b0),
    .ea         (ind_ea),
    .page_cross (ind_cross)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ptr_lo_d     = ptr_lo_q;
    idx_d        = idx_q;
    ea_work_d    = ea_work_q;
    cross_work_d = cross_work_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    ea_d         = ea_q;
    page_cross_d = page_cross_q;
    op_valid_d   = 1'b0;
    mode_err_d   = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          alu_a_d = reg_a;
          if (dec_imm) begin
            alu_b_d      = opnd_lo;
            ea_d         = 16'h0000;
            page_cross_d = 1'b0;
            op_valid_d   = 1'b1;
            mode_err_d   = is_reserved_mode(addr_mode);
          end else if (dec_ind) begin
            ptr_d   = dec_ptr;
            idx_d   = dec_ind_idx;
            state_d = ST_PTR_LO;
          end else begin
            ea_work_d    = dir_ea;
            cross_work_d = dir_cross;
            state_d      = (dir_cross && penalty_en) ? ST_FIX : ST_RD;
          end
        end
      end
      ST_PTR_LO: begin
        mem_rd   = 1'b1;
        mem_addr = {ZERO_PAGE, ptr_q};
        state_d  = ST_PTR_HI;
      end
      ST_PTR_HI: begin
        mem_rd   = 1'b1;
        mem_addr = {ZERO_PAGE, ptr_next};
        ptr_lo_d = mem_rdata;
        state_d  = ST_EA_FORM;
      end
      ST_EA_FORM: begin
        ea_work_d    = ind_ea;
        cross_work_d = ind_cross;
        state_d      = (ind_cross && penalty_en) ? ST_FIX : ST_RD;
      end
      ST_FIX: state_d = ST_RD;
      ST_RD: begin
        mem_rd   = 1'b1;
        mem_addr = ea_work_q;
        state_d  = ST_CAP;
      end
      ST_CAP: begin
        alu_b_d      = mem_rdata;
        ea_d         = ea_work_q;
        page_cross_d = cross_work_q;
        op_valid_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 8'h00;
      ptr_lo_q     <= 8'h00;
      idx_q        <= 8'h00;
      ea_work_q    <= 16'h0000;
      cross_work_q <= 1'b0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      ea_q         <= 16'h0000;
      page_cross_q <= 1'b0;
      op_valid_q   <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ptr_lo_q     <= ptr_lo_d;
      idx_q        <= idx_d;
      ea_work_q    <= ea_work_d;
      cross_work_q <= cross_work_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      ea_q         <= ea_d;
      page_cross_q <= page_cross_d;
      op_valid_q   <= op_valid_d;
      mode_err_q   <= mode_err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign op_valid   = op_valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign ea         = ea_q;
  assign page_cross = page_cross_q;
  assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench: runs PAGE_PENALTY=0 and =1 instances side by side on
// shared stimulus and compares both against an arithmetic reference model.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  addr_mode;
  logic [7:0]  opnd_lo, opnd_hi, reg_a, reg_x, reg_y;

  logic [15:0] mem_addr   [2];
  logic        mem_rd     [2];
  logic [7:0]  mem_rdata  [2];
  logic        busy       [2];
  logic        op_valid   [2];
  logic [7:0]  alu_a      [2];
  logic [7:0]  alu_b      [2];
  logic [15:0] ea         [2];
  logic        page_cross [2];
  logic        mode_err   [2];

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_operand_fetch #(.PAGE_PENALTY(g)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .addr_mode  (addr_mode),
      .opnd_lo    (opnd_lo),
      .opnd_hi    (opnd_hi),
      .reg_a      (reg_a),
      .reg_x      (reg_x),
      .reg_y      (reg_y),
      .mem_addr   (mem_addr[g]),
      .mem_rd     (mem_rd[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g]),
      .op_valid   (op_valid[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .ea         (ea[g]),
      .page_cross (page_cross[g]),
      .mode_err   (mode_err[g])
    );
  end

  // Synchronous memory: data for a read appears the cycle after mem_rd.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (mem_rd[g]) mem_rdata[g] <= mem[mem_addr[g]];
  end

  logic [15:0] rdq0[$], rdq1[$];
  int ov_cnt [2];
  int viol_cnt;

  always @(negedge clk) begin
    if (mem_rd[0]) rdq0.push_back(mem_addr[0]);
    if (mem_rd[1]) rdq1.push_back(mem_addr[1]);
    for (int g = 0; g < 2; g++) begin
      if (op_valid[g]) ov_cnt[g]++;
      if (!mem_rd[g] && mem_addr[g] != 16'h0000) viol_cnt++;
      if (op_valid[g] && busy[g]) viol_cnt++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int   lat;
    int   b;
    int   ea;
    int   pc;
    int   err;
    int   nrd;
    int   rd [3];
  } exp_t;

  // Reference: effective address and timing from the addressing-mode rules.
  function automatic exp_t model(input int m, input int lo, input int hi,
                                 input int x, input int y, input int pen);
    exp_t r;
    int base, e, p, idx;
    r.err = (m > 8) ? 1 : 0;
    if (m > 8) m = 0;
    r.pc = 0; r.nrd = 0; r.rd[0] = 0; r.rd[1] = 0; r.rd[2] = 0;
    e = 0;
    idx = (m == 2 || m == 5) ? x : (m == 3 || m == 6) ? y : 0;
    case (m)
      0: begin r.lat = 1; r.b = lo; r.ea = 0; return r; end
      1, 2, 3: begin e = (lo + idx) % 256; r.lat = 3; end
      4, 5, 6: begin
        base = hi * 256 + lo;
        e = (base + idx) % 65536;
        r.pc = (e / 256 != hi) ? 1 : 0;
        r.lat = 3 + ((r.pc == 1 && pen == 1) ? 1 : 0);
      end
      default: begin
        p = (m == 7) ? (lo + x) % 256 : lo;
        base = int'(mem[(p + 1) % 256]) * 256 + int'(mem[p]);
        e = (m == 7) ? base : (base + y) % 65536;
        r.pc = (e / 256 != base / 256) ? 1 : 0;
        r.lat = 6 + ((r.pc == 1 && pen == 1) ? 1 : 0);
        r.rd[0] = p; r.rd[1] = (p + 1) % 256; r.nrd = 2;
      end
    endcase
    r.rd[r.nrd] = e;
    r.nrd++;
    r.ea = e;
    r.b = int'(mem[e]);
    return r;
  endfunction

  task automatic run_op(input logic [3:0] m, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] a, input logic [7:0] x, input logic [7:0] y);
    exp_t e [2];
    bit   seen [2];
    int   lat_g [2];
    logic [7:0]  b_g [2], a_g [2];
    logic [15:0] ea_g [2];
    logic        pc_g [2], err_g [2];
    logic [15:0] q [$];
    for (int g = 0; g < 2; g++) begin
      e[g] = model(int'(m), int'(lo), int'(hi), int'(x), int'(y), g);
      seen[g] = 1'b0; lat_g[g] = 0;
      b_g[g] = 8'h00; a_g[g] = 8'h00; ea_g[g] = 16'h0000; pc_g[g] = 1'b0; err_g[g] = 1'b0;
    end
    rdq0.delete(); rdq1.delete();
    addr_mode = m; opnd_lo = lo; opnd_hi = hi; reg_a = a; reg_x = x; reg_y = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    addr_mode = 4'($urandom); opnd_lo = 8'($urandom); opnd_hi = 8'($urandom);
    reg_a = 8'($urandom); reg_x = 8'($urandom); reg_y = 8'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!seen[g] && op_valid[g]) begin
          seen[g] = 1'b1; lat_g[g] = k;
          b_g[g] = alu_b[g]; a_g[g] = alu_a[g]; ea_g[g] = ea[g];
          pc_g[g] = page_cross[g]; err_g[g] = mode_err[g];
        end
      end
      if (seen[0] && seen[1]) break;
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("latency m%0h p%0d", m, g), 32'(lat_g[g]), 32'(e[g].lat));
      check($sformatf("alu_b m%0h p%0d", m, g), 32'(b_g[g]), 32'(e[g].b));
      check($sformatf("alu_a m%0h p%0d", m, g), 32'(a_g[g]), 32'(a));
      check($sformatf("ea m%0h p%0d", m, g), 32'(ea_g[g]), 32'(e[g].ea));
      check($sformatf("page_cross m%0h p%0d", m, g), 32'(pc_g[g]), 32'(e[g].pc));
      check($sformatf("mode_err m%0h p%0d", m, g), 32'(err_g[g]), 32'(e[g].err));
      q = (g == 0) ? rdq0 : rdq1;
      check($sformatf("read_count m%0h p%0d", m, g), 32'(q.size()), 32'(e[g].nrd));
      for (int i = 0; i < e[g].nrd && i < q.size(); i++)
        check($sformatf("read_addr%0d m%0h p%0d", i, m, g), 32'(q[i]), 32'(e[g].rd[i]));
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int ov_snap [2];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; addr_mode = 4'h0;
    opnd_lo = 8'h00; opnd_hi = 8'h00; reg_a = 8'h00; reg_x = 8'h00; reg_y = 8'h00;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst busy p%0d", g), 32'(busy[g]), 32'd0);
      check($sformatf("rst mem_rd p%0d", g), 32'(mem_rd[g]), 32'd0);
      check($sformatf("rst mem_addr p%0d", g), 32'(mem_addr[g]), 32'd0);
      check($sformatf("rst op_valid p%0d", g), 32'(op_valid[g]), 32'd0);
      check($sformatf("rst outputs p%0d", g),
            {alu_a[g], alu_b[g], ea[g]}, 32'd0);
      check($sformatf("rst flags p%0d", g), 32'({page_cross[g], mode_err[g]}), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the addressing-mode examples.
    run_op(4'h0, 8'h5A, 8'h00, 8'h11, 8'h00, 8'h00);
    mem[16'h0010] = 8'h77;
    run_op(4'h2, 8'hF0, 8'h00, 8'h22, 8'h20, 8'h00);
    mem[16'h1300] = 8'hC3;
    run_op(4'h5, 8'hFF, 8'h12, 8'h33, 8'h01, 8'h00);
    mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h20; mem[16'h2005] = 8'h9E;
    run_op(4'h8, 8'hFF, 8'h00, 8'h44, 8'h00, 8'h05);
    run_op(4'h6, 8'hF0, 8'hFF, 8'h55, 8'h00, 8'h20);
    run_op(4'hF, 8'hA5, 8'h00, 8'h66, 8'h00, 8'h00);

    // Back-to-back: IMM accepted in the ZP op_valid cycle.
    mem[16'h0040] = 8'hAB;
    addr_mode = 4'h1; opnd_lo = 8'h40; reg_a = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("b2b zp op_valid p%0d", g), 32'(op_valid[g]), 32'd1);
      check($sformatf("b2b zp alu_b p%0d", g), 32'(alu_b[g]), 32'hAB);
    end
    addr_mode = 4'h0; opnd_lo = 8'h3C; reg_a = 8'h99; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("b2b imm op_valid p%0d", g), 32'(op_valid[g]), 32'd1);
      check($sformatf("b2b imm alu_b p%0d", g), 32'(alu_b[g]), 32'h3C);
      check($sformatf("b2b imm alu_a p%0d", g), 32'(alu_a[g]), 32'h99);
    end
    @(negedge clk);

    // start held while busy must be ignored.
    mem[16'h3456] = 8'h5E;
    ov_snap[0] = ov_cnt[0]; ov_snap[1] = ov_cnt[1];
    addr_mode = 4'h4; opnd_lo = 8'h56; opnd_hi = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    addr_mode = 4'h0; opnd_lo = 8'hEE;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    repeat (8) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("busy_ignore pulses p%0d", g), 32'(ov_cnt[g] - ov_snap[g]), 32'd1);
      check($sformatf("busy_ignore alu_b p%0d", g), 32'(alu_b[g]), 32'h5E);
    end

    // Reset during cycle 2 of an INDX sequence aborts it.
    ov_snap[0] = ov_cnt[0]; ov_snap[1] = ov_cnt[1];
    addr_mode = 4'h7; opnd_lo = 8'h10; reg_x = 8'h02; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("abort mem_rd p%0d", g), 32'(mem_rd[g]), 32'd0);
      check($sformatf("abort busy p%0d", g), 32'(busy[g]), 32'd0);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("abort no op_valid p%0d", g), 32'(ov_cnt[g] - ov_snap[g]), 32'd0);

    // Randomized operations, with occasional idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (2) @(negedge clk);
    check("idle address / busy-valid overlap", 32'(viol_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
